// File: rtl/jk_universal_shift_reg_pkg.sv
// Shared types and helpers for the JK-cell universal shift register.
package jk_universal_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Excitation that makes a JK cell behave as a D element: returns {j, k}.
    function automatic logic [1:0] jk_excite(input logic d, input logic q);
        return {d & ~q, ~d & q};
    endfunction

endpackage

// File: rtl/jk_universal_shift_reg_if.sv
// Control, data and status bundle of the universal shift register.
interface jk_universal_shift_reg_if
    import jk_universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             en;
    mode_e            mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             word_done;

    modport master (
        output en, mode, sin_r, sin_l, pdata,
        input  q, sout_r, sout_l, word_done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pdata,
        output q, sout_r, sout_l, word_done
    );
endinterface

// File: rtl/jk_ff_sr.sv
// JK flip-flop with synchronous active-high reset: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff_sr (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end
endmodule

// File: rtl/jk_universal_shift_reg.sv
// Universal shift register built from JK cells, with a shift counter that pulses word_done
// once every WIDTH shifts since the last load, reset or wrap.
module jk_universal_shift_reg
    import jk_universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    jk_universal_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [CNT_W-1:0] cnt;
    logic             word_done_r;

    // With en low d equals q, so every cell sees J=K=0 and holds.
    always_comb begin
        d = q_r;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: d = q_r;
                MODE_SHR:  d = {bus.sin_r, q_r[WIDTH-1:1]};
                MODE_SHL:  d = {q_r[WIDTH-2:0], bus.sin_l};
                MODE_LOAD: d = bus.pdata;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j[i], k[i]} = jk_excite(d[i], q_r[i]);

        jk_ff_sr u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q_r[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            word_done_r <= 1'b0;
        end else if (!bus.en) begin
            word_done_r <= 1'b0;
        end else begin
            case (bus.mode)
                MODE_SHR, MODE_SHL: begin
                    if (cnt == CNT_MAX) begin
                        cnt         <= '0;
                        word_done_r <= 1'b1;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        word_done_r <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    cnt         <= '0;
                    word_done_r <= 1'b0;
                end
                default: begin
                    word_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.sout_r    = q_r[0];
    assign bus.sout_l    = q_r[WIDTH-1];
    assign bus.word_done = word_done_r;
endmodule

// File: tb/tb_jk_universal_shift_reg.sv
// Directed and randomized checks of jk_universal_shift_reg against an arithmetic reference model.
module tb_jk_universal_shift_reg;
    import jk_universal_shift_reg_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    logic             m_wd;

    jk_universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    jk_universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shifts counted as integers, word boundary every WIDTH shifts.
    task automatic updateModel();
        if (rst) begin
            m_q = '0; m_cnt = 0; m_wd = 1'b0;
        end else if (!bus.en) begin
            m_wd = 1'b0;
        end else begin
            case (bus.mode)
                MODE_HOLD: m_wd = 1'b0;
                MODE_LOAD: begin m_q = bus.pdata; m_cnt = 0; m_wd = 1'b0; end
                default: begin
                    if (bus.mode == MODE_SHR)
                        m_q = (m_q >> 1) | (WIDTH'(bus.sin_r) << (WIDTH - 1));
                    else
                        m_q = (m_q << 1) | WIDTH'(bus.sin_l);
                    m_cnt = m_cnt + 1;
                    m_wd  = (m_cnt == WIDTH);
                    if (m_cnt == WIDTH) m_cnt = 0;
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic sr,
                                 input logic sl, input logic [WIDTH-1:0] pd);
        bus.en    = e;
        bus.mode  = mode_e'(m);
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.pdata = pd;
        @(posedge clk);
        updateModel();
        #1;
        checkOutput("q", 32'(bus.q), 32'(m_q));
        checkOutput("sout_r", 32'(bus.sout_r), 32'(m_q[0]));
        checkOutput("sout_l", 32'(bus.sout_l), 32'(m_q[WIDTH-1]));
        checkOutput("word_done", 32'(bus.word_done), 32'(m_wd));
    endtask

    initial begin
        logic [7:0] sout_seq;
        logic [7:0] frozen;
        sout_seq = 8'b1010_0101;
        m_q = '0; m_cnt = 0; m_wd = 1'b0;

        // Reset beats a load request.
        rst = 1'b1;
        repeat (2) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
        checkOutput("reset_q", 32'(bus.q), 32'h00);
        checkOutput("reset_wd", 32'(bus.word_done), 32'h0);
        rst = 1'b0;

        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            checkOutput("a5_sout_r", 32'(bus.sout_r), 32'(sout_seq[7-i]));
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            checkOutput("a5_wd", 32'(bus.word_done), 32'(i == 7));
        end
        checkOutput("a5_final_q", 32'(bus.q), 32'h00);

        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        repeat (3) applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        checkOutput("shl_q", 32'(bus.q), 32'h0F);
        checkOutput("shl_wd", 32'(bus.word_done), 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
            checkOutput("shl_cnt3_wd", 32'(bus.word_done), 32'(i == 4));
        end

        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        repeat (4) applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        frozen = bus.q;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 8'hFF);
            checkOutput("freeze_q", 32'(bus.q), 32'(frozen));
            checkOutput("freeze_wd", 32'(bus.word_done), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            checkOutput("resume_wd", 32'(bus.word_done), 32'(i == 3));
        end

        repeat (7) applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        checkOutput("load_wins_q", 32'(bus.q), 32'h3C);
        checkOutput("load_wins_wd", 32'(bus.word_done), 32'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 2'(1 + (i % 2)), 1'($urandom), 1'($urandom), 8'h00);
            checkOutput("burst_wd", 32'(bus.word_done), 32'(i == 7 || i == 15));
        end

        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
                          1'($urandom), 8'($urandom));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
